// File: rtl/cacheline_mem_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one burst memory port,
// splitting each line into BURST_LEN beats and reassembling read beats into a line.
module cacheline_mem_arbiter #(
    parameter int BEAT_W     = 64,
    parameter int BURST_LEN  = 4,
    parameter int D_PRIORITY = 0
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [31:0]                 i_dfp_addr,
    input  logic                        i_dfp_read,
    output logic [BEAT_W*BURST_LEN-1:0] i_dfp_rdata,
    output logic                        i_dfp_resp,

    input  logic [31:0]                 d_dfp_addr,
    input  logic                        d_dfp_read,
    input  logic                        d_dfp_write,
    input  logic [BEAT_W*BURST_LEN-1:0] d_dfp_wdata,
    output logic [BEAT_W*BURST_LEN-1:0] d_dfp_rdata,
    output logic                        d_dfp_resp,

    output logic [31:0]                 bmem_addr,
    output logic                        bmem_read,
    output logic                        bmem_write,
    output logic [BEAT_W-1:0]           bmem_wdata,
    input  logic                        bmem_ready,
    input  logic [31:0]                 bmem_raddr,
    input  logic [BEAT_W-1:0]           bmem_rdata,
    input  logic                        bmem_rvalid
);

    localparam int LINE_W = BEAT_W * BURST_LEN;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DATA,
        WR,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic                owner_is_d_q, owner_is_d_d;
    logic                op_write_q, op_write_d;
    logic                last_grant_d_q, last_grant_d_d;
    logic [31:0]         addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;

    logic                i_req;
    logic                d_req;
    logic                grant_d;
    logic [31:0]         grant_addr;
    logic [BEAT_W-1:0]   wr_beat;

    logic                unused_offset_bits;
    assign unused_offset_bits = ^{i_dfp_addr[OFF_W-1:0], d_dfp_addr[OFF_W-1:0]};

    assign i_req = i_dfp_read;
    assign d_req = d_dfp_read | d_dfp_write;

    // Contention goes to D when prioritised, otherwise to whoever was not granted last.
    always_comb begin
        grant_d    = 1'b0;
        grant_addr = i_dfp_addr;
        if (d_req && (!i_req || (D_PRIORITY != 0) || !last_grant_d_q)) begin
            grant_d    = 1'b1;
            grant_addr = d_dfp_addr;
        end
    end

    always_comb begin
        wr_beat = '0;
        for (int k = 0; k < BURST_LEN; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                wr_beat = d_dfp_wdata[BEAT_W*k +: BEAT_W];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_is_d_d   = owner_is_d_q;
        op_write_d     = op_write_q;
        last_grant_d_d = last_grant_d_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        line_d         = line_q;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    owner_is_d_d   = grant_d;
                    last_grant_d_d = grant_d;
                    op_write_d     = grant_d && d_dfp_write;
                    addr_d         = {grant_addr[31:OFF_W], {OFF_W{1'b0}}};
                    cnt_d          = '0;
                    state_d        = (grant_d && d_dfp_write) ? WR : RD_REQ;
                end
            end
            RD_REQ: begin
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bmem_rvalid) begin
                    for (int k = 0; k < BURST_LEN; k++) begin
                        if (cnt_q == CNT_W'(k)) begin
                            line_d[BEAT_W*k +: BEAT_W] = bmem_rdata;
                        end
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WR: begin
                if (bmem_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = RESP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_is_d_q   <= 1'b0;
            op_write_q     <= 1'b0;
            last_grant_d_q <= 1'b1;
            addr_q         <= '0;
            cnt_q          <= '0;
            line_q         <= '0;
        end else begin
            state_q        <= state_d;
            owner_is_d_q   <= owner_is_d_d;
            op_write_q     <= op_write_d;
            last_grant_d_q <= last_grant_d_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            line_q         <= line_d;
        end
    end

    // Outputs are decoded purely from state so nothing leaks while IDLE.
    always_comb begin
        bmem_addr   = '0;
        bmem_read   = 1'b0;
        bmem_write  = 1'b0;
        bmem_wdata  = '0;
        i_dfp_resp  = 1'b0;
        i_dfp_rdata = '0;
        d_dfp_resp  = 1'b0;
        d_dfp_rdata = '0;

        case (state_q)
            RD_REQ: begin
                bmem_addr = addr_q;
                bmem_read = 1'b1;
            end
            RD_DATA: begin
                bmem_addr = addr_q;
            end
            WR: begin
                bmem_addr  = addr_q;
                bmem_write = 1'b1;
                bmem_wdata = wr_beat;
            end
            RESP: begin
                bmem_addr = addr_q;
                if (owner_is_d_q) begin
                    d_dfp_resp = 1'b1;
                    if (!op_write_q) begin
                        d_dfp_rdata = line_q;
                    end
                end else begin
                    i_dfp_resp  = 1'b1;
                    i_dfp_rdata = line_q;
                end
            end
            default: begin
            end
        endcase
    end

`ifndef SYNTHESIS
    a_no_d_read_and_write: assert property (@(posedge clk) disable iff (rst)
        !(d_dfp_read && d_dfp_write));

    a_raddr_matches: assert property (@(posedge clk) disable iff (rst)
        (state_q == RD_DATA && bmem_rvalid) |-> (bmem_raddr == addr_q));
`endif

endmodule
